power_domain_resp16: RTL and testbench

//  Power-domain-side responder to the power controller sequencer. Models the switchable

---
 rtl/power_domain_resp16.sv | 210 +++++++++++++++++++++
 tb/tb_power_domain_resp16.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_domain_resp16.sv
`default_nettype none
// ============================================================================
// Module   : power_domain_resp16
// Purpose  : Switchable-domain responder: power-switch ramps/acks, live register
//            image, retention shadow save/restore, controller protocol checking.
//            Optional err_code output enabled by defining PD_RESP_ERR_CODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module power_domain_resp16 #(
    parameter int RAMP1_CYC = 8,
    parameter int RAMP2_CYC = 12,
    parameter int DN_CYC    = 4,
    parameter int DATA_W    = 32
) (
    input  logic              pclk16,
    input  logic              nprst16,
    input  logic              pwr1_on,
    input  logic              pwr2_on,
    input  logic              isolate_module,
    input  logic              gate_clk_module,
    input  logic              rstn_non_srpg_module,
    input  logic              save_edge,
    input  logic              restore_edge,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic              pwr1_ack,
    output logic              pwr2_ack,
    output logic              domain_on,
    output logic              ret_valid,
    output logic              save_done,
    output logic              restore_done,
    output logic [DATA_W-1:0] data_out,
`ifdef PD_RESP_ERR_CODE_EN
    output logic [2:0]        err_code,
`endif
    output logic              seq_error
);

    localparam int MAX_RAMP = (RAMP1_CYC > RAMP2_CYC) ? RAMP1_CYC : RAMP2_CYC;
    localparam int MAX_CYC  = (MAX_RAMP > DN_CYC) ? MAX_RAMP : DN_CYC;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_R1  = CNT_W'(RAMP1_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_R2  = CNT_W'(RAMP2_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_DN  = CNT_W'(DN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_ON       = 3'd0,
        ST_RAMP_DN  = 3'd1,
        ST_OFF      = 3'd2,
        ST_RAMP_UP1 = 3'd3,
        ST_WAIT2    = 3'd4,
        ST_RAMP_UP2 = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             set_ack1, set_ack2, clr_acks;
    logic             unsafe_off, ramp_abort;
    logic             is_on, both_edges, save_ok, restore_ok, err_save, err_rest, new_err;
    logic [DATA_W-1:0] shadow;

    always_ff @(posedge pclk16 or negedge nprst16) begin
        if (!nprst16) begin
            state <= ST_ON;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Ramp-up states abort to RAMP_DN if pwr1_on drops; RAMP_DN always runs to OFF.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt != '0) ? cnt - CNT_ONE : cnt;
        set_ack1   = 1'b0;
        set_ack2   = 1'b0;
        clr_acks   = 1'b0;
        unsafe_off = 1'b0;
        ramp_abort = 1'b0;
        case (state)
            ST_ON: begin
                if (!pwr1_on) begin
                    state_nxt  = ST_RAMP_DN;
                    cnt_nxt    = CNT_DN;
                    unsafe_off = ~isolate_module | ~ret_valid;
                end
            end
            ST_RAMP_DN: begin
                if (cnt == '0) begin
                    state_nxt = ST_OFF;
                    clr_acks  = 1'b1;
                end
            end
            ST_OFF: begin
                if (pwr1_on) begin
                    state_nxt = ST_RAMP_UP1;
                    cnt_nxt   = CNT_R1;
                end
            end
            ST_RAMP_UP1: begin
                if (!pwr1_on) begin
                    state_nxt  = ST_RAMP_DN;
                    cnt_nxt    = CNT_DN;
                    ramp_abort = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = ST_WAIT2;
                    set_ack1  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (!pwr1_on) begin
                    state_nxt  = ST_RAMP_DN;
                    cnt_nxt    = CNT_DN;
                    ramp_abort = 1'b1;
                end else if (pwr2_on) begin
                    state_nxt = ST_RAMP_UP2;
                    cnt_nxt   = CNT_R2;
                end
            end
            ST_RAMP_UP2: begin
                if (!pwr1_on) begin
                    state_nxt  = ST_RAMP_DN;
                    cnt_nxt    = CNT_DN;
                    ramp_abort = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = ST_ON;
                    set_ack2  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ON;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign is_on      = (state == ST_ON);
    assign both_edges = save_edge & restore_edge;
    assign save_ok    = save_edge & ~restore_edge & is_on & isolate_module & gate_clk_module;
    assign restore_ok = restore_edge & ~save_edge & is_on & isolate_module & ret_valid;
    assign err_save   = save_edge & ~restore_edge & ~save_ok;
    assign err_rest   = restore_edge & ~save_edge & ~restore_ok;
    assign new_err    = both_edges | err_save | err_rest | unsafe_off | ramp_abort;
    assign domain_on  = pwr1_ack & pwr2_ack;

    always_ff @(posedge pclk16 or negedge nprst16) begin
        if (!nprst16) begin
            pwr1_ack     <= 1'b1;
            pwr2_ack     <= 1'b1;
            ret_valid    <= 1'b0;
            save_done    <= 1'b0;
            restore_done <= 1'b0;
            shadow       <= '0;
            data_out     <= '0;
            seq_error    <= 1'b0;
        end else begin
            if (set_ack1)
                pwr1_ack <= 1'b1;
            else if (clr_acks)
                pwr1_ack <= 1'b0;
            if (set_ack2)
                pwr2_ack <= 1'b1;
            else if (clr_acks)
                pwr2_ack <= 1'b0;
            save_done    <= save_ok;
            restore_done <= restore_ok;
            if (save_ok) begin
                shadow    <= data_out;
                ret_valid <= 1'b1;
            end else if (restore_ok) begin
                ret_valid <= 1'b0;
            end
            // Outside ON the unretained flops are unpowered and read back as zero.
            if (restore_ok)
                data_out <= shadow;
            else if (!is_on || !rstn_non_srpg_module)
                data_out <= '0;
            else if (!gate_clk_module)
                data_out <= data_in;
            seq_error <= new_err | (seq_error & ~err_clr);
        end
    end

`ifdef PD_RESP_ERR_CODE_EN
    logic [2:0] cause;

    always_comb begin
        cause = 3'd0;
        if (both_edges)      cause = 3'd3;
        else if (err_save)   cause = 3'd1;
        else if (err_rest)   cause = 3'd2;
        else if (unsafe_off) cause = 3'd4;
        else if (ramp_abort) cause = 3'd5;
    end

    always_ff @(posedge pclk16 or negedge nprst16) begin
        if (!nprst16)
            err_code <= 3'd0;
        else if (err_clr)
            err_code <= cause;
        else if (!seq_error && new_err)
            err_code <= cause;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_power_domain_resp16.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for power_domain_resp16: directed power-shutoff scenarios then
// randomized controller behaviour, checked against a cycle-level reference model.
module tb_power_domain_resp16;

    localparam int R1 = 8;
    localparam int R2 = 12;
    localparam int DN = 4;
    localparam int P_ON = 0, P_DN = 1, P_OFF = 2, P_UP1 = 3, P_WAIT = 4, P_UP2 = 5;

    logic        pclk16 = 1'b0;
    logic        nprst16 = 1'b0;
    logic        pwr1_on = 1'b1, pwr2_on = 1'b1, isolate_module = 1'b0;
    logic        gate_clk_module = 1'b0, rstn_non_srpg_module = 1'b1;
    logic        save_edge = 1'b0, restore_edge = 1'b0, err_clr = 1'b0;
    logic [31:0] data_in = '0;
    logic        pwr1_ack, pwr2_ack, domain_on, ret_valid, save_done, restore_done, seq_error;
    logic [31:0] data_out;
    logic [2:0]  err_code;

    always #5 pclk16 = ~pclk16;

    power_domain_resp16 dut (
        .pclk16(pclk16), .nprst16(nprst16), .pwr1_on(pwr1_on), .pwr2_on(pwr2_on),
        .isolate_module(isolate_module), .gate_clk_module(gate_clk_module),
        .rstn_non_srpg_module(rstn_non_srpg_module), .save_edge(save_edge),
        .restore_edge(restore_edge), .data_in(data_in), .err_clr(err_clr),
        .pwr1_ack(pwr1_ack), .pwr2_ack(pwr2_ack), .domain_on(domain_on),
        .ret_valid(ret_valid), .save_done(save_done), .restore_done(restore_done),
        .data_out(data_out),
`ifdef PD_RESP_ERR_CODE_EN
        .err_code(err_code),
`endif
        .seq_error(seq_error)
    );
`ifndef PD_RESP_ERR_CODE_EN
    assign err_code = 3'd0;
`endif

    typedef struct packed {
        logic        a1, a2, on, rv, sd, rd, se;
        logic [2:0]  code;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    logic        s_p1 = 1'b1, s_p2 = 1'b1, s_iso = 1'b0, s_gclk = 1'b0, s_srpg = 1'b1;
    logic        s_sv = 1'b0, s_rs = 1'b0, s_clr = 1'b0;
    logic [31:0] s_din = '0;

    // reference model state
    int          m_phase, m_left;
    logic        m_a1, m_a2, m_rv, m_sd, m_rd, m_err;
    logic [2:0]  m_code;
    logic [31:0] m_shadow, m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_ON; m_left = 0; m_a1 = 1; m_a2 = 1; m_rv = 0; m_sd = 0; m_rd = 0;
        m_err = 0; m_code = 0; m_shadow = 0; m_data = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.a1 = m_a1; e.a2 = m_a2; e.on = m_a1 & m_a2; e.rv = m_rv; e.sd = m_sd;
        e.rd = m_rd; e.se = m_err; e.code = m_code; e.d = m_data;
        return e;
    endfunction

    task automatic model_step();
        bit          on, sv_ok, rs_ok, ramping;
        int          cause;
        logic [31:0] nd;
        on      = (m_phase == P_ON);
        ramping = (m_phase == P_UP1) || (m_phase == P_WAIT) || (m_phase == P_UP2);
        sv_ok   = s_sv && !s_rs && on && s_iso && s_gclk;
        rs_ok   = s_rs && !s_sv && on && s_iso && m_rv;
        cause = 0;
        if (s_sv && s_rs)                       cause = 3;
        else if (s_sv && !sv_ok)                cause = 1;
        else if (s_rs && !rs_ok)                cause = 2;
        else if (on && !s_p1 && !(s_iso && m_rv)) cause = 4;
        else if (ramping && !s_p1)              cause = 5;
        if (rs_ok)                   nd = m_shadow;
        else if (!on || !s_srpg)     nd = 0;
        else if (!s_gclk)            nd = s_din;
        else                         nd = m_data;
        if (sv_ok) begin m_shadow = m_data; m_rv = 1; end
        else if (rs_ok) m_rv = 0;
        m_data = nd; m_sd = sv_ok; m_rd = rs_ok;
        if (s_clr)                         m_code = 3'(cause);
        else if (!m_err && cause != 0)     m_code = 3'(cause);
        m_err = (cause != 0) || (m_err && !s_clr);
        if (ramping && !s_p1) begin
            m_phase = P_DN; m_left = DN;
        end else begin
            case (m_phase)
                P_ON:   if (!s_p1) begin m_phase = P_DN; m_left = DN; end
                P_DN:   begin m_left--; if (m_left == 0) begin m_phase = P_OFF; m_a1 = 0; m_a2 = 0; end end
                P_OFF:  if (s_p1) begin m_phase = P_UP1; m_left = R1; end
                P_UP1:  begin m_left--; if (m_left == 0) begin m_phase = P_WAIT; m_a1 = 1; end end
                P_WAIT: if (s_p2) begin m_phase = P_UP2; m_left = R2; end
                P_UP2:  begin m_left--; if (m_left == 0) begin m_phase = P_ON; m_a2 = 1; end end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(negedge pclk16);
        nprst16 = 1'b1;
        pwr1_on = s_p1; pwr2_on = s_p2; isolate_module = s_iso; gate_clk_module = s_gclk;
        rstn_non_srpg_module = s_srpg; save_edge = s_sv; restore_edge = s_rs;
        err_clr = s_clr; data_in = s_din;
        model_step();
        q.push_back(model_out());
        s_sv = 1'b0; s_rs = 1'b0; s_clr = 1'b0;
        @(posedge pclk16);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the chosen ack reaches 'want'; reports edges after the sampling edge.
    task automatic measure(input int sel, input logic want, input int exp_n, input string name);
        int   n;
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (sel == 1) ? pwr1_ack : pwr2_ack;
        end while (v !== want && n < 60);
        chk(name, n - 1, exp_n);
    endtask

    always @(posedge pclk16) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pwr1_ack", pwr1_ack, e.a1);
            chk("pwr2_ack", pwr2_ack, e.a2);
            chk("domain_on", domain_on, e.on);
            chk("ret_valid", ret_valid, e.rv);
            chk("save_done", save_done, e.sd);
            chk("restore_done", restore_done, e.rd);
            chk("seq_error", seq_error, e.se);
            chk("data_out", data_out, e.d);
`ifdef PD_RESP_ERR_CODE_EN
            chk("err_code", err_code, e.code);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        chk("reset_acks", {pwr1_ack, pwr2_ack, domain_on}, 3'b111);
        chk("reset_flags", {ret_valid, save_done, restore_done, seq_error}, 4'b0000);
        chk("reset_data", data_out, 32'h0);

        // Legal power shut-off and restore
        s_din = 32'hA5A5_0001; s_gclk = 0; step();
        s_gclk = 1; s_iso = 1; step();
        s_sv = 1; step();
        chk("save_done_pulse", save_done, 1'b1);
        s_p1 = 0; s_p2 = 0;
        measure(1, 1'b0, DN, "dn_latency");
        steps(3);
        s_p1 = 1;
        measure(1, 1'b1, R1, "ramp1_latency");
        s_p2 = 1;
        measure(2, 1'b1, R2, "ramp2_latency");
        s_rs = 1; step();
        chk("restore_done_pulse", restore_done, 1'b1);
        chk("restored_data", data_out, 32'hA5A5_0001);
        chk("pso_no_error", seq_error, 1'b0);

        // Restore attempted while still ramping
        s_sv = 1; step();
        s_p1 = 0; s_p2 = 0; steps(6);
        s_p1 = 1; steps(10);
        s_p2 = 1; steps(3);
        s_rs = 1; step();
        chk("early_restore_err", seq_error, 1'b1);
        chk("early_restore_data", data_out, 32'h0);
        chk("early_restore_rv", ret_valid, 1'b1);
`ifdef PD_RESP_ERR_CODE_EN
        chk("early_restore_code", err_code, 3'd2);
`endif
        steps(12);
        s_clr = 1; step();
        chk("clr_no_error", seq_error, 1'b0);

        // Simultaneous save and restore
        s_sv = 1; s_rs = 1; step();
        chk("both_edges_err", seq_error, 1'b1);
        chk("both_edges_pulses", {save_done, restore_done}, 2'b00);
`ifdef PD_RESP_ERR_CODE_EN
        chk("both_edges_code", err_code, 3'd3);
`endif
        s_clr = 1; s_sv = 1; s_gclk = 0; step();
        chk("clr_with_new_err", seq_error, 1'b1);
        s_gclk = 1; s_clr = 1; step();
        s_rs = 1; step();
        chk("shadow_kept", data_out, 32'hA5A5_0001);

        // Unsafe power-off without isolation
        s_iso = 0; s_p1 = 0; s_p2 = 0;
        measure(1, 1'b0, DN, "unsafe_dn_latency");
        chk("unsafe_off_err", seq_error, 1'b1);
        s_clr = 1; step();

        // Reset in the middle of RAMP_UP1
        s_p1 = 1; steps(3);
        @(negedge pclk16);
        nprst16 = 1'b0;
        model_reset();
        q.push_back(model_out());
        #1;
        chk("async_reset_acks", {pwr1_ack, pwr2_ack, domain_on}, 3'b111);
        @(posedge pclk16);
        #2;

        for (int i = 0; i < 1500; i++) begin
            if (s_p1) s_p1 = ($urandom_range(0, 99) >= 3);
            else      s_p1 = ($urandom_range(0, 99) < 15);
            s_p2   = ($urandom_range(0, 99) < 70);
            s_iso  = ($urandom_range(0, 99) < 75);
            s_gclk = ($urandom_range(0, 99) < 60);
            s_srpg = ($urandom_range(0, 99) < 92);
            s_sv   = ($urandom_range(0, 99) < 6);
            s_rs   = ($urandom_range(0, 99) < 6);
            s_clr  = ($urandom_range(0, 99) < 10);
            s_din  = $urandom;
            step();
        end

        @(posedge pclk16);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
